sprite_layer_compositor: RTL and testbench
==========================================

SPRITE_LAYER_COMPOSITOR -- requirements
Module: sprite_layer_compositor

Interface
REQ-001 Parameter LATENCY, default 4, meaning cycles from timing inputs to arrival of sprite_pixel_in/bg_pixel_in for the same coordinate; legal range 1..8.
REQ-002 Parameter KEY_COLOR, default 12'h000, meaning the transparent sprite colour.
REQ-003 pixel_clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-005 hcount_in  input  11  horizontal pixel count from the timing generator.
REQ-006 vcount_in  input  10  vertical line count from the timing generator.
REQ-007 hsync_in, vsync_in, blank_in  input  1 each  timing strobes aligned with hcount_in/vcount_in.
REQ-008 sprite_pixel_in  input  12  RGB444 from the sprite stage (0 outside sprite), valid LATENCY cycles after its coordinate.
REQ-009 bg_pixel_in  input  12  RGB444 background, same alignment as sprite_pixel_in.
REQ-010 layer_en_in  input  1  request to show the sprite layer; sampled once per frame.
REQ-011 pixel_out  output  12  composited RGB444.
REQ-012 hsync_out, vsync_out, blank_out  output  1 each  timing strobes aligned with pixel_out.
REQ-013 frame_start_out  output  1  one-cycle pulse coincident with pixel_out for coordinate (0,0).

Function
REQ-014 Timing delay line: hcount, vcount, hsync, vsync, blank each pass through a LATENCY-stage shift register, so stage LATENCY aligns with sprite_pixel_in/bg_pixel_in.
REQ-015 Output stage is one register; pixel_out, hsync_out, vsync_out, blank_out, frame_start_out appear LATENCY+1 cycles after the corresponding timing input.
REQ-016 Aligned frame start = aligned hcount==0 and aligned vcount==0; frame_start_out is that condition registered.
REQ-017 layer_en latch loads layer_en_in only in the cycle of aligned frame start; holds otherwise; changes of layer_en_in mid-frame have no visible effect until the next frame.
REQ-018 Mix: if aligned blank==1, pixel_out = 12'h000; else if latched layer_en==1 and sprite pixel is opaque, pixel_out = sprite_pixel_in; else pixel_out = bg_pixel_in.
REQ-019 Opacity rule is per Configuration REQ-025/026; comparison is full 12-bit equality.
REQ-020 Back-to-back frames, wrap of hcount/vcount to 0, and frame start coinciding with blank are handled identically to REQ-016..018 (blank still forces 0; latch still loads).
REQ-021 No backpressure; one pixel accepted and produced every cycle.

Reset
REQ-022 While rst_n_in==0: all delay stages, pixel_out, hsync_out, vsync_out, blank_out, frame_start_out = 0; latched layer_en = 0.
REQ-023 Reset deassertion mid-frame: delay line refills over LATENCY+1 cycles emitting zeros; sprite layer stays hidden until the first aligned frame start after reset.
REQ-024 Reset assertion is asynchronous; outputs reach 0 without waiting for a clock edge.

Configuration
REQ-025 With COMPOSITOR_CHROMA_KEY_EN defined: sprite pixel opaque iff sprite_pixel_in != KEY_COLOR.
REQ-026 Without COMPOSITOR_CHROMA_KEY_EN: KEY_COLOR ignored; sprite pixel opaque iff sprite_pixel_in != 12'h000.

Verification
REQ-027 LATENCY=4, hsync_in pulse at cycle 10 -> hsync_out high at cycle 15 only; blank/vsync same offset.
REQ-028 layer_en_in=1 before frame start, sprite=12'hF00, bg=12'h00F, blank=0 -> pixel_out=12'hF00; sprite=12'h000 -> 12'h00F.
REQ-029 layer_en_in toggled 1->0 mid-frame -> sprite still shown for rest of frame; hidden from next frame_start_out onward.
REQ-030 blank_in=1 with sprite=12'hFFF, bg=12'hFFF -> pixel_out=12'h000 after LATENCY+1 cycles.
REQ-031 COMPOSITOR_CHROMA_KEY_EN defined, KEY_COLOR=12'hF0F: sprite=12'hF0F -> bg shown; sprite=12'h000 -> 12'h000 shown; macro undefined -> sprite 12'hF0F shown.
REQ-032 rst_n_in pulled low mid-line -> all outputs 0 immediately; after release, frame_start_out first pulses at next (0,0) + LATENCY+1, sprite hidden until then.

Source files
------------

// File: rtl/sprite_layer_compositor.sv
// Sprite/background compositor: delays raster timing to match pixel data and mixes one pixel per clock.
// Define COMPOSITOR_CHROMA_KEY_EN to make KEY_COLOR the transparent sprite colour (otherwise 12'h000).
module sprite_layer_compositor #(
  parameter int          LATENCY   = 4,
  parameter logic [11:0] KEY_COLOR = 12'h000
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [11:0] sprite_pixel_in,
  input  logic [11:0] bg_pixel_in,
  input  logic        layer_en_in,
  output logic [11:0] pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        frame_start_out
);

`ifdef COMPOSITOR_CHROMA_KEY_EN
  localparam logic [11:0] TRANSPARENT = KEY_COLOR;
`else
  localparam logic [11:0] TRANSPARENT = 12'h000;
  logic unused_key;
  assign unused_key = ^KEY_COLOR;
`endif

  logic [10:0]        h_dly [LATENCY];
  logic [9:0]         v_dly [LATENCY];
  logic [LATENCY-1:0] hs_dly;
  logic [LATENCY-1:0] vs_dly;
  logic [LATENCY-1:0] bl_dly;
  logic [LATENCY-1:0] vld_dly;
  logic               layer_en_q;

  logic [10:0] h_al;
  logic [9:0]  v_al;
  logic        hs_al, vs_al, bl_al, vld_al;
  logic        frame_start_al;
  logic        layer_en_eff;
  logic        sprite_opaque;

  // The valid bit keeps the zeroed stages after reset from posing as coordinate (0,0).
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < LATENCY; i++) begin
        h_dly[i] <= '0;
        v_dly[i] <= '0;
      end
      hs_dly  <= '0;
      vs_dly  <= '0;
      bl_dly  <= '0;
      vld_dly <= '0;
    end else begin
      h_dly[0]   <= hcount_in;
      v_dly[0]   <= vcount_in;
      hs_dly[0]  <= hsync_in;
      vs_dly[0]  <= vsync_in;
      bl_dly[0]  <= blank_in;
      vld_dly[0] <= 1'b1;
      for (int i = 1; i < LATENCY; i++) begin
        h_dly[i]   <= h_dly[i-1];
        v_dly[i]   <= v_dly[i-1];
        hs_dly[i]  <= hs_dly[i-1];
        vs_dly[i]  <= vs_dly[i-1];
        bl_dly[i]  <= bl_dly[i-1];
        vld_dly[i] <= vld_dly[i-1];
      end
    end
  end

  assign h_al   = h_dly[LATENCY-1];
  assign v_al   = v_dly[LATENCY-1];
  assign hs_al  = hs_dly[LATENCY-1];
  assign vs_al  = vs_dly[LATENCY-1];
  assign bl_al  = bl_dly[LATENCY-1];
  assign vld_al = vld_dly[LATENCY-1];

  assign frame_start_al = vld_al && (h_al == 11'd0) && (v_al == 10'd0);
  // The (0,0) pixel already uses the newly sampled enable.
  assign layer_en_eff   = frame_start_al ? layer_en_in : layer_en_q;
  assign sprite_opaque  = (sprite_pixel_in != TRANSPARENT);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      layer_en_q      <= 1'b0;
      pixel_out       <= '0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      blank_out       <= 1'b0;
      frame_start_out <= 1'b0;
    end else begin
      layer_en_q <= layer_en_eff;
      if (!vld_al) begin
        pixel_out       <= '0;
        hsync_out       <= 1'b0;
        vsync_out       <= 1'b0;
        blank_out       <= 1'b0;
        frame_start_out <= 1'b0;
      end else begin
        if (bl_al)
          pixel_out <= 12'h000;
        else if (layer_en_eff && sprite_opaque)
          pixel_out <= sprite_pixel_in;
        else
          pixel_out <= bg_pixel_in;
        hsync_out       <= hs_al;
        vsync_out       <= vs_al;
        blank_out       <= bl_al;
        frame_start_out <= frame_start_al;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Self-checking bench for sprite_layer_compositor: directed vectors, corner sequences and random rasters
// checked every cycle against a history-based reference model.
module tb_sprite_layer_compositor;

  localparam int          L      = 4;
  localparam logic [11:0] KEY    = 12'hF0F;
  localparam int          HT     = 20;
  localparam int          VT     = 6;
  localparam int          NPIX   = HT * VT;
  localparam int          HISTSZ = 8192;
`ifdef COMPOSITOR_CHROMA_KEY_EN
  localparam logic [11:0] MODEL_KEY = KEY;
`else
  localparam logic [11:0] MODEL_KEY = 12'h000;
`endif

  logic        pixel_clk_in = 1'b0;
  logic        rst_n_in     = 1'b1;
  logic [10:0] hcount_in    = '0;
  logic [9:0]  vcount_in    = '0;
  logic        hsync_in     = 1'b0;
  logic        vsync_in     = 1'b0;
  logic        blank_in     = 1'b0;
  logic [11:0] sprite_pixel_in = '0;
  logic [11:0] bg_pixel_in  = '0;
  logic        layer_en_in  = 1'b0;
  logic [11:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out, frame_start_out;

  sprite_layer_compositor #(.LATENCY(L), .KEY_COLOR(KEY)) dut (
    .pixel_clk_in    (pixel_clk_in),
    .rst_n_in        (rst_n_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .blank_in        (blank_in),
    .sprite_pixel_in (sprite_pixel_in),
    .bg_pixel_in     (bg_pixel_in),
    .layer_en_in     (layer_en_in),
    .pixel_out       (pixel_out),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .blank_out       (blank_out),
    .frame_start_out (frame_start_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  typedef struct {
    logic [11:0] sp;
    logic [11:0] bg;
    logic        bl;
    logic        hs;
    logic        vs;
    logic [11:0] exp_pix;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_valid = 0;
  int pos = 0;
  logic lat_model = 1'b0;

  logic [10:0] h_hist  [HISTSZ];
  logic [9:0]  v_hist  [HISTSZ];
  logic        hs_hist [HISTSZ];
  logic        vs_hist [HISTSZ];
  logic        bl_hist [HISTSZ];

  logic        rand_mode = 1'b0;
  logic        blank00   = 1'b0;
  logic        len_now   = 1'b0;
  logic [11:0] sp_fix    = '0;
  logic [11:0] bg_fix    = '0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] outVec();
    return {pixel_out, hsync_out, vsync_out, blank_out, frame_start_out};
  endfunction

  // One clock: drive, clock, predict from the coordinate presented L cycles earlier, compare.
  task automatic applyStimulus(input logic [10:0] h, input logic [9:0] v, input logic hs,
                               input logic vs, input logic bl, input logic [11:0] sp,
                               input logic [11:0] bg, input logic len);
    int e, c;
    logic fs, eff;
    logic [11:0] pix;
    logic [15:0] exp;
    hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs; blank_in = bl;
    sprite_pixel_in = sp; bg_pixel_in = bg; layer_en_in = len;
    h_hist[cyc] = h; v_hist[cyc] = v; hs_hist[cyc] = hs; vs_hist[cyc] = vs; bl_hist[cyc] = bl;
    @(posedge pixel_clk_in);
    e = cyc;
    cyc++;
    exp = '0;
    if (e - L >= first_valid) begin
      c   = e - L;
      fs  = (h_hist[c] == 11'd0) && (v_hist[c] == 10'd0);
      eff = fs ? len : lat_model;
      lat_model = eff;
      if (bl_hist[c])                     pix = 12'h000;
      else if (eff && (sp != MODEL_KEY))  pix = sp;
      else                                pix = bg;
      exp = {pix, hs_hist[c], vs_hist[c], bl_hist[c], fs};
    end
    #1;
    checkOutput("model", outVec(), exp);
  endtask

  // Walks a small raster (HT x VT, last 4 columns and last line blanked).
  task automatic rasterTicks(input int n);
    logic [10:0] h;
    logic [9:0]  v;
    logic bl, hs, vs;
    logic [11:0] sp, bg;
    for (int i = 0; i < n; i++) begin
      h  = 11'(pos % HT);
      v  = 10'((pos / HT) % VT);
      bl = (h >= 11'd16) || (v >= 10'd5) || (blank00 && h == 11'd0 && v == 10'd0);
      hs = (h == 11'd17) || (h == 11'd18);
      vs = (v == 10'd5);
      if (rand_mode) begin
        case ($urandom_range(0, 3))
          0:       sp = 12'h000;
          1:       sp = KEY;
          default: sp = 12'($urandom_range(0, 4095));
        endcase
        bg = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 29) == 0) len_now = ~len_now;
      end else begin
        sp = sp_fix;
        bg = bg_fix;
      end
      applyStimulus(h, v, hs, vs, bl, sp, bg, len_now);
      pos++;
    end
  endtask

  vec_t vecs[7];
  int first_fs;
  int shown_early;

  initial begin
    vecs[0] = '{12'hF00, 12'h00F, 1'b0, 1'b0, 1'b0, 12'hF00};
    vecs[1] = '{12'h000, 12'h00F, 1'b0, 1'b0, 1'b0, 12'h00F};
    vecs[2] = '{12'hFFF, 12'hFFF, 1'b1, 1'b0, 1'b0, 12'h000};
`ifdef COMPOSITOR_CHROMA_KEY_EN
    vecs[3] = '{12'hF0F, 12'h0A0, 1'b0, 1'b0, 1'b0, 12'h0A0};
`else
    vecs[3] = '{12'hF0F, 12'h0A0, 1'b0, 1'b0, 1'b0, 12'hF0F};
`endif
    vecs[4] = '{12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000};
    vecs[5] = '{12'h5A3, 12'h1C7, 1'b0, 1'b0, 1'b1, 12'h5A3};
    vecs[6] = '{12'h5A3, 12'h1C7, 1'b1, 1'b1, 1'b1, 12'h000};

    #2 rst_n_in = 1'b0;
    #1 checkOutput("reset_state", outVec(), 16'h0000);
    repeat (3) @(posedge pixel_clk_in);
    @(negedge pixel_clk_in);
    rst_n_in = 1'b1;
    first_valid = cyc;
    lat_model = 1'b0;

    // Strobes presented in cycle 0 must appear exactly L+1 cycles later, i.e. after the L-th clock.
    for (int i = 0; i <= L + 4; i++) begin
      applyStimulus(11'd5, 10'd2, i == 0, i == 0, i == 0, 12'h000, 12'h000, 1'b0);
      checkOutput("strobe_delay", {13'd0, hsync_out, vsync_out, blank_out},
                  (i == L) ? 16'h0007 : 16'h0000);
    end

    // Latch the layer on at a frame start, then run the vector table.
    applyStimulus(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1);
    for (int i = 0; i < L; i++)
      applyStimulus(11'd1, 10'd0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1);
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i <= L; i++)
        applyStimulus(11'd3, 10'd1, vecs[k].hs, vecs[k].vs, vecs[k].bl, vecs[k].sp, vecs[k].bg, 1'b0);
      checkOutput($sformatf("vector_%0d", k), outVec(),
                  {vecs[k].exp_pix, vecs[k].hs, vecs[k].vs, vecs[k].bl, 1'b0});
    end

    // Layer enable dropped mid-frame: sprite stays until the next frame start.
    pos = 0; rand_mode = 1'b0; sp_fix = 12'hF00; bg_fix = 12'h00F; len_now = 1'b1;
    rasterTicks(70);
    len_now = 1'b0;
    rasterTicks(10);
    checkOutput("toggle_still_shown", {4'd0, pixel_out}, 16'h0F00);
    rasterTicks(NPIX - 80 + 5 + L);
    checkOutput("toggle_hidden_next", {4'd0, pixel_out}, 16'h000F);

    // Random frames, one with the frame-start pixel blanked.
    rand_mode = 1'b1;
    for (int f = 0; f < 16; f++) begin
      blank00 = (f == 5);
      rasterTicks(NPIX);
    end
    blank00 = 1'b0;

    // Asynchronous reset mid-line, then restart from the middle of a frame.
    #3 rst_n_in = 1'b0;
    #1 checkOutput("async_reset", outVec(), 16'h0000);
    repeat (2) @(posedge pixel_clk_in);
    @(negedge pixel_clk_in);
    rst_n_in = 1'b1;
    first_valid = cyc;
    lat_model = 1'b0;
    pos = 47; rand_mode = 1'b0; sp_fix = 12'hF00; bg_fix = 12'h00F; len_now = 1'b1;
    first_fs = -1;
    shown_early = 0;
    for (int i = 0; i < NPIX - 47 + L + 3; i++) begin
      rasterTicks(1);
      if (frame_start_out && first_fs < 0) first_fs = i;
      if (first_fs < 0 && pixel_out == 12'hF00) shown_early++;
    end
    checkOutput("first_fs_after_reset", 16'(first_fs), 16'(NPIX - 47 + L));
    checkOutput("hidden_before_fs", 16'(shown_early), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
